// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and default bit period.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS           = 8;
    localparam int unsigned STOP_BITS           = 1;
    localparam int unsigned DEFAULT_CLK_PER_BIT = 100;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a parameterized reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, samples at mid-bit and reports each byte
// with a one-cycle data_valid pulse, or a one-cycle frame_error on a low stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int unsigned          CNT_W    = $clog2(CLK_PER_BIT);
    localparam int unsigned          BIT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     HALF_CNT = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 serial_s;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (serial),
        .q_o  (serial_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!serial_s) begin
                    state_d = StStart;
                    bit_d   = '0;
                end
            end
            StStart: begin
                // Half a bit period lands the following samples at mid-bit.
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    state_d = serial_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    shift_d = {serial_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = '0;
                    if (serial_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitHigh: begin
                // Holding here makes a break report exactly one frame_error.
                if (serial_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of back-to-back frames at CPB=100 plus hand-written
// glitch, break, mid-frame reset and minimum-CPB sequences.
module tb_uart_rx;

    typedef struct {
        logic [7:0] value;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser100, ser4;
    logic [7:0] data100, data4;
    logic       v100, v4, fe100, fe4, busy100, busy4;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int nv100 = 0, ne100 = 0, nv4 = 0, ne4 = 0, both = 0;
    int vcyc100 = 0, vcyc4 = 0;
    logic [7:0] vdata100 = 8'h00, vdata4 = 8'h00;

    uart_rx #(.CLK_PER_BIT(100)) dut100 (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial     (ser100),
        .data       (data100),
        .data_valid (v100),
        .frame_error(fe100),
        .busy       (busy100)
    );

    uart_rx #(.CLK_PER_BIT(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial     (ser4),
        .data       (data4),
        .data_valid (v4),
        .frame_error(fe4),
        .busy       (busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v100) begin
            nv100++;
            vcyc100 = cyc;
            vdata100 = data100;
        end
        if (fe100) ne100++;
        if (v4) begin
            nv4++;
            vcyc4 = cyc;
            vdata4 = data4;
        end
        if (fe4) ne4++;
        if ((v100 && fe100) || (v4 && fe4)) both++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive_bit(input bit sel4, input logic v, input int n);
        if (sel4) ser4 = v;
        else ser100 = v;
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame starting at the current negedge; busy_ok reports busy at every mid data bit.
    task automatic send_frame(input bit sel4, input int cpb, input logic [7:0] b,
                              input logic stop, output bit busy_ok);
        busy_ok = 1'b1;
        drive_bit(sel4, 1'b0, cpb);
        for (int i = 0; i < 8; i++) begin
            drive_bit(sel4, b[i], cpb / 2);
            if (!(sel4 ? busy4 : busy100)) busy_ok = 1'b0;
            repeat (cpb - cpb / 2) @(negedge clk);
        end
        drive_bit(sel4, stop, cpb);
    endtask

    initial begin
        vec_t vecs[5];
        bit   ok;
        int   t0, nv_b, ne_b;
        logic [7:0] b81;

        vecs[0] = '{value: 8'h63, exp_data: 8'h63};
        vecs[1] = '{value: 8'h00, exp_data: 8'h00};
        vecs[2] = '{value: 8'hFF, exp_data: 8'hFF};
        vecs[3] = '{value: 8'hA5, exp_data: 8'hA5};
        vecs[4] = '{value: 8'h5A, exp_data: 8'h5A};

        rst_n  = 1'b0;
        ser100 = 1'b1;
        ser4   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", data100, 8'h00);
        check("rst_valid", v100, 1'b0);
        check("rst_ferr", fe100, 1'b0);
        check("rst_busy", busy100, 1'b0);
        check("rst_data4", data4, 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_busy", busy100, 1'b0);

        // Back-to-back frames: each stop bit is followed directly by the next start bit.
        for (int i = 0; i < 5; i++) begin
            nv_b = nv100;
            ne_b = ne100;
            t0   = cyc;
            send_frame(1'b0, 100, vecs[i].value, 1'b1, ok);
            check($sformatf("v%0d_pulses", i), nv100 - nv_b, 1);
            check($sformatf("v%0d_pdata", i), vdata100, vecs[i].exp_data);
            check($sformatf("v%0d_data", i), data100, vecs[i].exp_data);
            check($sformatf("v%0d_ferr", i), ne100 - ne_b, 0);
            check($sformatf("v%0d_busy", i), ok, 1'b1);
            check_range($sformatf("v%0d_latency", i), vcyc100 - t0, 952, 954);
        end
        repeat (20) @(negedge clk);
        check("hold_data", data100, 8'h5A);
        check("hold_busy", busy100, 1'b0);

        // 20-cycle low glitch: start-bit sample at mid-bit finds the line high again.
        nv_b = nv100;
        ne_b = ne100;
        ser100 = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_hi", busy100, 1'b1);
        repeat (10) @(negedge clk);
        ser100 = 1'b1;
        repeat (32) @(negedge clk);
        check("glitch_busy_52", busy100, 1'b1);
        repeat (2) @(negedge clk);
        check("glitch_busy_54", busy100, 1'b0);
        check("glitch_valid", nv100 - nv_b, 0);
        check("glitch_ferr", ne100 - ne_b, 0);

        // Break: low stop bit, then the line stays low for 30 bit times.
        nv_b = nv100;
        ne_b = ne100;
        send_frame(1'b0, 100, 8'h3C, 1'b0, ok);
        repeat (30 * 100) @(negedge clk);
        check("brk_ferr", ne100 - ne_b, 1);
        check("brk_valid", nv100 - nv_b, 0);
        check("brk_data", data100, 8'h5A);
        check("brk_busy", busy100, 1'b1);
        ser100 = 1'b1;
        repeat (5) @(negedge clk);
        check("brk_busy_rel", busy100, 1'b0);
        check("brk_ferr_once", ne100 - ne_b, 1);

        // Reset asserted in the middle of bit 4 of 0x81.
        nv_b = nv100;
        ne_b = ne100;
        b81  = 8'h81;
        drive_bit(1'b0, 1'b0, 100);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, b81[i], 100);
        drive_bit(1'b0, b81[4], 50);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_busy", busy100, 1'b0);
        check("mrst_data", data100, 8'h00);
        ser100 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("mrst_idle", busy100, 1'b0);
        check("mrst_nopulse", nv100 - nv_b, 0);
        send_frame(1'b0, 100, 8'h42, 1'b1, ok);
        repeat (20) @(negedge clk);
        check("mrst_pulses", nv100 - nv_b, 1);
        check("mrst_data42", data100, 8'h42);
        check("mrst_ferr", ne100 - ne_b, 0);

        // Minimum bit period.
        t0 = cyc;
        send_frame(1'b1, 4, 8'h96, 1'b1, ok);
        repeat (10) @(negedge clk);
        check("cpb4_pulses", nv4, 1);
        check("cpb4_data", data4, 8'h96);
        check("cpb4_pdata", vdata4, 8'h96);
        check("cpb4_ferr", ne4, 0);
        check("cpb4_busy", ok, 1'b1);
        check_range("cpb4_latency", vcyc4 - t0, 40, 42);

        check("valid_and_ferr", both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
